mainmem_responder: RTL
======================

Name: mainmem_responder

Overview:
- Main-memory end of the cache-fill / write-through interface that the cache arbiter drives.
- Single-port word memory that accepts one request per cycle.
- Writes commit at the sampling edge.
- Reads are fully pipelined: each read returns its data a fixed LATENCY cycles after issue, flagged by data_valid. The arbiter's fill FSMs rely on that flag to step through a block fill.

Parameters:
- ADDR_W, 15: word-address width; memory holds 2^ADDR_W 16-bit words.
- LATENCY, 4: read latency in cycles; legal range 1..8.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- enable  input  1  request valid this cycle.
- wr  input  1  with enable: 1 = write, 0 = read.
- addr  input  16  byte address; word index = addr[ADDR_W:1]; addr[0] ignored.
- data_in  input  16  write data.
- data_out  output  16  read data; valid only while data_valid = 1.
- data_valid  output  1  high for exactly one cycle per completed read.
- busy  output  1  high while at least one read is in flight or being returned.

Behaviour:
- Reset (asynchronous, takes effect immediately):
  - All pipeline valid bits clear, so data_valid = 0, data_out = 0 and busy = 0 at once.
  - Memory array contents are not altered by reset.
- Request sampling: enable, wr, addr and data_in are sampled on each rising edge; enable = 0 means no operation.
- Write:
  - Array word at addr[ADDR_W:1] takes data_in at the sampling edge.
  - No response: data_valid is never raised for a write.
- Read:
  - Array is read in the issue cycle; the word and a valid bit enter stage 1 of a LATENCY-deep shift pipeline.
  - Issue in cycle c gives data_valid = 1 with that word on data_out during cycle c+LATENCY.
- Throughput: one request per cycle, with no stalls or backpressure.
  - Back-to-back reads in cycles c..c+k return in cycles c+LATENCY..c+k+LATENCY, in issue order, with no gaps.
- data_out = 0 whenever data_valid = 0. It is driven from the final pipeline stage, not from an output hold register.
- Hazards:
  - A read issued the cycle after a write to the same word returns the new data.
  - A write that lands while an earlier read to the same word is in flight does not change that read's returned data; data is captured at issue.
- Address wrap: bits above addr[ADDR_W] are ignored (modulo 2^ADDR_W).
- busy = OR of all pipeline stage valid bits, including the final stage. It is combinational from registered state.
- Reset mid-operation: in-flight reads are discarded and never returned. Writes already committed remain in the array.
- LATENCY = 1: a read issued in cycle c returns in cycle c+1.

Test Plan:
- Reset with rst pulsed mid-cycle, no clock edge -> data_valid, data_out and busy drop to 0 immediately.
- Write 0xBEEF at addr 0x0010, then read 0x0010 next cycle (LATENCY = 4) -> data_valid high exactly 4 cycles after the read issue cycle, data_out = 0xBEEF, one-cycle pulse. busy is high for those 4 cycles.
- Preload 0x0000..0x0006 with 0x1111, 0x2222, 0x3333, 0x4444; issue 4 consecutive reads (mimicking a block fill) -> 4 consecutive valid cycles returning 0x1111, 0x2222, 0x3333, 0x4444 in order.
- Read 0x0020 (holding 0x00AA), then write 0x0020 = 0x5555 on the next cycle -> the read returns 0x00AA. A later read of 0x0020 returns 0x5555.
- Write 0x1234 at addr 0x0021, read addr 0x0020 -> 0x1234 (addr[0] ignored). Write 0x0042 = 0x7777 with enable = 0, then read 0x0042 -> old value is returned.
- Issue 3 reads, assert rst 2 cycles later, release and idle -> no data_valid pulse at any time. Memory retains values written before reset.

Source files
------------

// File: rtl/mainmem_responder.sv
// mainmem_responder: single-port word memory with a fixed-latency, fully pipelined read return.
module mainmem_responder #(
    parameter int ADDR_W  = 15,
    parameter int LATENCY = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic        wr,
    input  logic [15:0] addr,
    input  logic [15:0] data_in,
    output logic [15:0] data_out,
    output logic        data_valid,
    output logic        busy
);
    if (LATENCY < 1 || LATENCY > 8) begin : g_bad_latency
        $error("mainmem_responder: LATENCY must be 1..8");
    end
    logic [15:0]        mem_q [2**ADDR_W];
    logic [LATENCY-1:0] vld_q, vld_d;
    logic [15:0]        dat_q [LATENCY];
    logic [15:0]        dat_d [LATENCY];
    logic [ADDR_W-1:0]  idx;
    logic               rd_en;
    logic               unused_addr;
    assign idx         = addr[ADDR_W:1];
    assign rd_en       = enable & ~wr;
    assign unused_addr = addr[0] ^ (^(addr >> (ADDR_W + 1)));
    // Read data is captured at issue, so later writes never disturb an in-flight read.
    always_comb begin
        vld_d[0] = rd_en;
        dat_d[0] = rd_en ? mem_q[idx] : '0;
        for (int i = 1; i < LATENCY; i++) begin
            vld_d[i] = vld_q[i-1];
            dat_d[i] = dat_q[i-1];
        end
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_q <= '0;
            for (int i = 0; i < LATENCY; i++) dat_q[i] <= '0;
        end else begin
            vld_q <= vld_d;
            for (int i = 0; i < LATENCY; i++) dat_q[i] <= dat_d[i];
        end
    end
    always_ff @(posedge clk) begin
        if (enable && wr) mem_q[idx] <= data_in;
    end
    assign data_valid = vld_q[LATENCY-1];
    assign data_out   = data_valid ? dat_q[LATENCY-1] : '0;
    assign busy       = |vld_q;
endmodule
